// File: rtl/pid_step_ctrl.sv
// ---------------------------------------------------------------------------
// pid_step_ctrl -- multi-cycle PID controller, one control step per request.
//
// A request on start_i runs one step through a fixed sequence of states,
// each lasting one clock:
//   IDLE -> ERR -> INT -> MP -> MI -> MD -> SUM -> OUT -> IDLE
// A single signed W x W multiplier is shared by the three gain products.
// Each state's work is committed on the clock edge that leaves that state.
// As a result, done_o rises 7 cycles after the edge that samples start_i.
//
// Parameters
//   W        signed width of setpoint, measurement, gains, limits and output
//   FRAC     fractional bits of kp/ki/kd (gain 1.0 = 2**FRAC)
//   SHIFT_I  arithmetic right shift applied to the error before integration
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   start_i      request one step (sampled only in IDLE)
//   clr_i        clear integrator and previous error (sampled only in IDLE)
//   setpoint_i   signed reference
//   meas_i       signed plant measurement
//   kp_i/ki_i/kd_i  signed gains with FRAC fractional bits
//   out_min_i    signed lower output limit
//   out_max_i    signed upper output limit
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse; u_o and sat_o are valid
//   u_o          signed control output, held between steps
//   sat_o        high when the last u_o was clamped, held with u_o
//
// Configuration
//   PID_ANTIWINDUP_EN  when defined, the integrator holds in INT if the
//                      previous step ended at out_max with a positive error,
//                      or at out_min with a negative error.
// ---------------------------------------------------------------------------
module pid_step_ctrl #(
  parameter int W       = 32,
  parameter int FRAC    = 8,
  parameter int SHIFT_I = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         clr_i,
  input  logic [W-1:0] setpoint_i,
  input  logic [W-1:0] meas_i,
  input  logic [W-1:0] kp_i,
  input  logic [W-1:0] ki_i,
  input  logic [W-1:0] kd_i,
  input  logic [W-1:0] out_min_i,
  input  logic [W-1:0] out_max_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] u_o,
  output logic         sat_o
);

  localparam int PW = 2 * W;      // full product width
  localparam int SW = 2 * W + 2;  // sum width, wide enough for three products

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_INT,
    S_MP,
    S_MI,
    S_MD,
    S_SUM,
    S_OUT
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sat_q;
  logic signed [W-1:0]   u_q;

  // Operands captured in ERR so later input changes cannot disturb a step.
  logic signed [W-1:0]   kp_q;
  logic signed [W-1:0]   ki_q;
  logic signed [W-1:0]   kd_q;
  logic signed [W-1:0]   min_q;
  logic signed [W-1:0]   max_q;

  // Controller memory and pipeline registers.
  logic signed [W-1:0]   err_q;
  logic signed [W-1:0]   prev_err_q;
  logic signed [W-1:0]   integ_q;
  logic signed [W-1:0]   deriv_q;
  logic signed [PW-1:0]  p_q;
  logic signed [PW-1:0]  i_q;
  logic signed [PW-1:0]  d_q;
  logic signed [SW-1:0]  sum_q;

  // -------------------------------------------------------------------------
  // Next-state datapath values
  // -------------------------------------------------------------------------
  logic signed [W-1:0]   err_d;
  logic signed [W-1:0]   err_shr;
  logic signed [W-1:0]   integ_sum;
  logic signed [W-1:0]   integ_d;
  logic signed [W-1:0]   deriv_d;
  logic                  wind_hold;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic signed [PW-1:0]  mul_full;
  logic signed [PW-1:0]  prod_d;
  logic signed [SW-1:0]  sum_d;
  logic signed [SW-1:0]  lo_ext;
  logic signed [SW-1:0]  hi_ext;
  logic signed [W-1:0]   u_d;
  logic                  sat_d;

  // Reduce a W+1 bit two's-complement value to W bits, saturating at the
  // signed W-bit extremes instead of wrapping.
  function automatic logic signed [W-1:0] sat_w(input logic [W:0] x);
    logic signed [W-1:0] r;
    if (x[W] != x[W-1]) begin
      r = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      r = x[W-1:0];
    end
    return r;
  endfunction

  // Error: difference taken one bit wider so it cannot wrap before saturation.
  assign err_d = sat_w({setpoint_i[W-1], setpoint_i} - {meas_i[W-1], meas_i});

  // Integrator input is the scaled-down error; the sum saturates.
  assign err_shr   = err_q >>> SHIFT_I;
  assign integ_sum = sat_w({integ_q[W-1], integ_q} + {err_shr[W-1], err_shr});
  assign deriv_d   = sat_w({err_q[W-1], err_q} - {prev_err_q[W-1], prev_err_q});

`ifdef PID_ANTIWINDUP_EN
  // Stop integrating while the output is pinned at a limit and the error
  // would push it further into that limit.
  assign wind_hold = ((u_q == max_q) && !err_q[W-1] && (|err_q)) ||
                     ((u_q == min_q) &&  err_q[W-1]);
`else
  assign wind_hold = 1'b0;
`endif

  assign integ_d = wind_hold ? integ_q : integ_sum;

  // Shared multiplier operand select.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    mul_a = kd_q;
    mul_b = deriv_q;
    case (state_q)
      S_MP: begin
        mul_a = kp_q;
        mul_b = err_q;
      end
      S_MI: begin
        mul_a = ki_q;
        mul_b = integ_q;
      end
      default: begin
        mul_a = kd_q;
        mul_b = deriv_q;
      end
    endcase
  end

  // Sign-extending both operands to 2W bits makes the low 2W bits of the
  // product the exact signed W x W result.
  assign mul_full = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
  assign prod_d   = mul_full >>> FRAC;

  assign sum_d = {{2{p_q[PW-1]}}, p_q} +
                 {{2{i_q[PW-1]}}, i_q} +
                 {{2{d_q[PW-1]}}, d_q};

  assign lo_ext = {{(W+2){min_q[W-1]}}, min_q};
  assign hi_ext = {{(W+2){max_q[W-1]}}, max_q};

  // Output clamp. An inverted limit pair is treated as a hard clamp to max.
  always_comb begin
    u_d   = sum_q[W-1:0];
    sat_d = 1'b0;
    if (min_q > max_q) begin
      u_d   = max_q;
      sat_d = 1'b1;
    end else if (sum_q > hi_ext) begin
      u_d   = max_q;
      sat_d = 1'b1;
    end else if (sum_q < lo_ext) begin
      u_d   = min_q;
      sat_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer and registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      u_q        <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      kd_q       <= '0;
      min_q      <= '0;
      max_q      <= '0;
      err_q      <= '0;
      prev_err_q <= '0;
      integ_q    <= '0;
      deriv_q    <= '0;
      p_q        <= '0;
      i_q        <= '0;
      d_q        <= '0;
      sum_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Clear lands on the same edge that accepts start, so a combined
          // clr+start step integrates and differentiates from zero.
          if (clr_i) begin
            integ_q    <= '0;
            prev_err_q <= '0;
          end
          if (start_i) begin
            state_q <= S_ERR;
            busy_q  <= 1'b1;
          end
        end
        S_ERR: begin
          err_q   <= err_d;
          kp_q    <= kp_i;
          ki_q    <= ki_i;
          kd_q    <= kd_i;
          min_q   <= out_min_i;
          max_q   <= out_max_i;
          state_q <= S_INT;
        end
        S_INT: begin
          integ_q <= integ_d;
          deriv_q <= deriv_d;
          state_q <= S_MP;
        end
        S_MP: begin
          p_q     <= prod_d;
          state_q <= S_MI;
        end
        S_MI: begin
          i_q     <= prod_d;
          state_q <= S_MD;
        end
        S_MD: begin
          d_q     <= prod_d;
          state_q <= S_SUM;
        end
        S_SUM: begin
          sum_q   <= sum_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          // start_i is deliberately not looked at here; a held request is
          // picked up on the following IDLE cycle.
          u_q        <= u_d;
          sat_q      <= sat_d;
          prev_err_q <= err_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign u_o    = u_q;
  assign sat_o  = sat_q;

endmodule
